// File: rtl/cond_pkg.sv
// Shared condition-code, flag-index and skid-buffer state definitions for the
// execute-to-writeback stage and future branch logic.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: pass = cond(flags), zero latency.
// No state, no handshake; the reserved code 1111 never passes.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, n, c, v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_stage.sv
// Registers ALU output, holds NZCV, gates writeback on the condition; 1-cycle latency.
// Stalls via out_ready; COND_FLAGS_SKID_EN adds a 2-entry skid with registered in_ready.
module cond_flags_stage
  import cond_pkg::*;
#(
  parameter int N        = 32,
  parameter int REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_result,
  input  logic [3:0]          in_flags,
  input  logic [3:0]          in_cond,
  input  logic                in_set_flags,
  input  logic                in_wr_en,
  input  logic [REG_BITS-1:0] in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_result,
  output logic [REG_BITS-1:0] out_rd,
  output logic                out_wr_en,
  output logic                out_cond_pass,
  output logic [3:0]          flags_q
);

  buf_state_e state, state_nxt;
  logic       cond_pass;
  logic       accept;
  logic       drain;
  logic       load0_in;

  cond_check u_cond_check (
    .cond  (in_cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign out_valid = (state != EMPTY);
  assign drain     = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

`ifdef COND_FLAGS_SKID_EN
  logic                load0_s1;
  logic                load1_in;
  logic                in_ready_q;
  logic [N-1:0]        res1;
  logic [REG_BITS-1:0] rd1;
  logic                wr1;
  logic                pass1;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_comb begin
    state_nxt = state;
    load0_in  = 1'b0;
`ifdef COND_FLAGS_SKID_EN
    load0_s1  = 1'b0;
    load1_in  = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load0_in  = 1'b1;
        end
      end
      ONE: begin
`ifdef COND_FLAGS_SKID_EN
        if (accept && drain) begin
          load0_in = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load1_in  = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
`else
        if (accept) begin
          load0_in = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
`endif
      end
      TWO: begin
`ifdef COND_FLAGS_SKID_EN
        if (drain) begin
          state_nxt = ONE;
          load0_s1  = 1'b1;
        end
`else
        state_nxt = EMPTY;
`endif
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result    <= '0;
      out_rd        <= '0;
      out_wr_en     <= 1'b0;
      out_cond_pass <= 1'b0;
      flags_q       <= 4'b0000;
`ifdef COND_FLAGS_SKID_EN
      in_ready_q    <= 1'b1;
      res1          <= '0;
      rd1           <= '0;
      wr1           <= 1'b0;
      pass1         <= 1'b0;
`endif
    end else begin
      if (load0_in) begin
        out_result    <= in_result;
        out_rd        <= in_rd;
        out_wr_en     <= in_wr_en && cond_pass;
        out_cond_pass <= cond_pass;
      end
`ifdef COND_FLAGS_SKID_EN
      else if (load0_s1) begin
        out_result    <= res1;
        out_rd        <= rd1;
        out_wr_en     <= wr1;
        out_cond_pass <= pass1;
      end
      if (load1_in) begin
        res1  <= in_result;
        rd1   <= in_rd;
        wr1   <= in_wr_en && cond_pass;
        pass1 <= cond_pass;
      end
      in_ready_q <= (state_nxt != TWO);
`endif
      // Commit on the accepting edge so the next instruction sees new flags.
      if (accept && cond_pass && in_set_flags) begin
        flags_q <= in_flags;
      end
    end
  end

endmodule

// File: tb/tb_cond_flags_stage.sv
// Directed, table-driven bench for cond_flags_stage in either buffer build.
module tb_cond_flags_stage;

`ifdef COND_FLAGS_SKID_EN
  localparam int SLOTS = 2;
`else
  localparam int SLOTS = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_cond;
  logic        in_set_flags;
  logic        in_wr_en;
  logic [3:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic        out_cond_pass;
  logic [3:0]  flags_q;

  int checks = 0;
  int errors = 0;

  cond_flags_stage #(.N(32), .REG_BITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_flags      (in_flags),
    .in_cond       (in_cond),
    .in_set_flags  (in_set_flags),
    .in_wr_en      (in_wr_en),
    .in_rd         (in_rd),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_wr_en     (out_wr_en),
    .out_cond_pass (out_cond_pass),
    .flags_q       (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  prev;
    logic [3:0]  cond;
    logic        sf;
    logic [3:0]  fl;
    logic        wr;
    logic [3:0]  rd;
    logic [31:0] res;
    logic        exp_pass;
    logic        exp_wr;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: even codes name a predicate, odd codes invert it.
  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cy, v, r;
    z  = f[3];
    n  = f[2];
    cy = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    if (c == 4'b1111) r = 1'b0;
    return r;
  endfunction

  task automatic send(input logic [3:0] c, input logic sf, input logic [3:0] fl,
                      input logic wr, input logic [3:0] rd, input logic [31:0] res);
    in_valid     = 1'b1;
    in_cond      = c;
    in_set_flags = sf;
    in_flags     = fl;
    in_wr_en     = wr;
    in_rd        = rd;
    in_result    = res;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int    idx;
    int    got[$];
    int    vals[3];
    logic  acc;
    vals[0] = 10;
    vals[1] = 20;
    vals[2] = 30;

    //            prev     cond     sf    fl       wr    rd     res  pass  wr    flags
    vecs[0] = '{4'b0000, 4'b1110, 1'b1, 4'b1000, 1'b0, 4'd0, 32'd0,  1'b1, 1'b0, 4'b1000};
    vecs[1] = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'd1, 32'd7,  1'b1, 1'b1, 4'b1000};
    vecs[2] = '{4'b1000, 4'b0001, 1'b0, 4'b0000, 1'b1, 4'd2, 32'd8,  1'b0, 1'b0, 4'b1000};
    vecs[3] = '{4'b0000, 4'b0000, 1'b1, 4'b0110, 1'b1, 4'd4, 32'd9,  1'b0, 1'b0, 4'b0000};
    vecs[4] = '{4'b0101, 4'b1010, 1'b1, 4'b0010, 1'b1, 4'd5, 32'd11, 1'b1, 1'b1, 4'b0010};
    vecs[5] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'd6, 32'd12, 1'b0, 1'b0, 4'b1111};
    vecs[6] = '{4'b0010, 4'b1000, 1'b0, 4'b0000, 1'b1, 4'd7, 32'd13, 1'b1, 1'b1, 4'b0010};
    vecs[7] = '{4'b0001, 4'b1101, 1'b0, 4'b0000, 1'b1, 4'd8, 32'd14, 1'b1, 1'b1, 4'b0001};
    vecs[8] = '{4'b1010, 4'b1011, 1'b0, 4'b0000, 1'b1, 4'd9, 32'd15, 1'b0, 1'b0, 4'b1010};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_result    = '0;
    in_flags     = '0;
    in_cond      = '0;
    in_set_flags = 1'b0;
    in_wr_en     = 1'b0;
    in_rd        = '0;
    out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", flags_q, 0);
    check("rst_result", out_result, 0);
    check("rst_rd", out_rd, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_cond_pass", out_cond_pass, 0);

    // First transaction: one cycle to out_valid.
    send(4'b1110, 1'b1, 4'b1000, 1'b1, 4'd3, 32'd5);
    check("first_valid", out_valid, 1);
    check("first_wr_en", out_wr_en, 1);
    check("first_rd", out_rd, 3);
    check("first_result", out_result, 5);
    check("first_flags", flags_q, 4'b1000);
    idle(2);
    check("first_drained", out_valid, 0);

    // Table: preload flags with an AL set-flags entry, then the vector back to back.
    for (int i = 0; i < 9; i++) begin
      send(4'b1110, 1'b1, vecs[i].prev, 1'b0, 4'd0, 32'd0);
      send(vecs[i].cond, vecs[i].sf, vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].res);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_pass", i), out_cond_pass, vecs[i].exp_pass);
      check($sformatf("vec%0d_wr_en", i), out_wr_en, vecs[i].exp_wr);
      check($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
      check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      check($sformatf("vec%0d_flags", i), flags_q, vecs[i].exp_flags);
      idle(1);
    end

    // Full sweep of condition codes against every flag value.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        send(4'b1110, 1'b1, 4'(f), 1'b0, 4'd0, 32'd0);
        send(4'(c), 1'b0, 4'b0000, 1'b1, 4'(c), 32'(f * 16 + c));
        check($sformatf("sweep_c%0d_f%0d_pass", c, f), out_cond_pass, model(4'(c), 4'(f)));
        check($sformatf("sweep_c%0d_f%0d_wr", c, f), out_wr_en, model(4'(c), 4'(f)));
      end
    end
    idle(2);

    // Backpressure: three entries with in_valid held while writeback stalls.
    idx          = 0;
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_cond      = 4'b1110;
    in_set_flags = 1'b0;
    in_wr_en     = 1'b1;
    in_rd        = 4'd1;
    in_result    = 32'(vals[0]);
    for (int cyc = 0; cyc < 30 && got.size() < 3; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(int'(out_result));
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx >= 3) in_valid = 1'b0;
      else in_result = 32'(vals[idx]);
      if (cyc == 3) begin
        check("bp_accepted_before_stall", idx, SLOTS);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_output_held", out_result, 10);
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("bp_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) begin
      check($sformatf("bp_order%0d", i), got[i], vals[i]);
    end
    idle(2);
    check("bp_empty", out_valid, 0);

    // Reset with the buffer full discards everything.
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_cond      = 4'b1110;
    in_set_flags = 1'b1;
    in_flags     = 4'b0100;
    in_result    = 32'd99;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_flags", flags_q, 4'b0100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_flags", flags_q, 0);
    check("midrst_wr_en", out_wr_en, 0);
    out_ready = 1'b1;
    idle(2);
    check("midrst_no_writeback", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
